expr_result_unpacker: RTL and testbench
=======================================

# expr_result_unpacker

Receive-side companion to the vloghammer expression blocks. Each expression module packs 18 result fields (y0..y17, 90 bits) into one output vector. This block accepts that vector as a narrow beat stream and reassembles it. It then emits the fields one per handshake, zero- or sign-extended per field type, so the checker compares field by field.

## Interface

Parameters:
- BEAT_W, default 10: input beat width; must divide 90 (legal values 10, 15, 18, 30, 45, 90). N_BEATS = 90/BEAT_W.
- OUT_W, default 8: output field width; must be ≥ 6.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- in_valid  in  1  beat valid.
- in_ready  out  1  block accepts a beat.
- in_data  in  BEAT_W  beat, MSB-first: beat 0 carries y[89:90-BEAT_W].
- in_last  in  1  marks the final beat of a frame.
- out_valid  out  1  field valid.
- out_ready  in  1  consumer accepts the field.
- out_idx  out  5  field index 0..17 (0 = y0).
- out_data  out  OUT_W  field value, extended to OUT_W.
- out_signed  out  1  field is a signed type.
- out_last  out  1  high with idx 17.
- frame_err  out  1  one-cycle pulse on a framing error.

## Operation

- Field layout, for k = 0..17:
  - g = k/6, j = k%6.
  - Width w = 4, 5, 6 for j%3 = 0, 1, 2.
  - Signed when j ≥ 3.
  - MSB = 89 − 30g − off[j], where off = 0, 4, 9, 15, 19, 24. So y0 = [89:86], y5 = [65:60], y17 = [5:0].
- Extension: signed fields replicate bit w−1 into the upper bits of out_data; unsigned fields zero-fill.
- State COLLECT:
  - in_ready = 1, out_valid = 0.
  - On each in_valid && in_ready, the 90-bit shift register shifts left by BEAT_W and loads in_data into the LSBs; the beat counter increments.
- Framing in COLLECT:
  - in_last on beat count < N_BEATS−1: frame_err pulse, frame discarded, counter cleared, stay in COLLECT.
  - Beat N_BEATS−1 accepted without in_last: frame_err pulse, frame discarded, counter cleared, stay in COLLECT.
  - Beat N_BEATS−1 with in_last: go to EMIT with field index 0.
- State EMIT:
  - in_ready = 0.
  - out_valid = 1, with out_idx, out_data, out_signed and out_last derived from the held shift register and the current index.
  - On out_valid && out_ready, the index increments.
  - The handshake at idx 17 returns the block to COLLECT with counter 0.
- Backpressure: while out_ready = 0, all out_* signals hold stable. The shift register is frozen for the whole of EMIT.
- The counter and index never wrap inside a state. Leaving a state always resets them.

## Timing

- Reset:
  - out_valid = 0, out_idx = 0, out_data = 0, out_signed = 0, out_last = 0, frame_err = 0.
  - in_ready = 0 while rst = 1 and goes high the first cycle after rst deasserts.
  - The shift register and counter clear; state = COLLECT.
- Reset mid-frame or mid-EMIT: the partial or undelivered frame is discarded; no frame_err is raised.
- Latency: last beat accepted at edge T; out_valid = 1 with idx 0 from cycle T+1.
- Throughput: one field per cycle when out_ready is held high. The minimum frame period is N_BEATS + 18 cycles (27 at the defaults). Input and output do not overlap.
- frame_err is registered and asserted for exactly the cycle after the offending beat's handshake.
- in_last is ignored unless in_valid && in_ready.

## Test plan

- All-ones frame (9 beats of 10'h3FF, in_last on beat 8): out_data equals
  - 8'h0F, 8'h1F, 8'h3F for idx 0–2;
  - 8'hFF for idx 3–5;
  - the same pattern repeats for groups 1 and 2.
  
  out_last is high only at idx 17, and out_valid rises the cycle after beat 8.
- Sign check (beats 0, 0, 10'h020, then six zero beats): idx 5 yields out_data = 8'hE0 with out_signed = 1; every other field yields 8'h00.
- Single LSB (eight zero beats, then 10'h001): idx 17 yields 8'h01. A frame with only bit 89 set (10'h200 first beat) yields 8'h08 at idx 0.
- Framing errors:
  - in_last on beat 3: frame_err pulses once and no output appears. A following correct frame decodes normally.
  - Nine beats with no in_last: frame_err pulses and no output appears.
- Backpressure: out_ready toggles 1,0,0,1 throughout EMIT. out_* stay stable while stalled, all 18 indices appear in order exactly once, and in_ready stays 0 until the idx-17 handshake completes.
- Reset mid-EMIT at idx 7: out_valid = 0 on the cycle after reset. The next full frame decodes from idx 0 with no frame_err.

Source files
------------

// File: rtl/expr_result_unpacker.sv
// expr_result_unpacker
// Reassembles a 90-bit expression result vector (y0..y17) from a narrow
// MSB-first beat stream, then presents the 18 fields one per handshake,
// zero- or sign-extended to OUT_W bits. Collection and emission alternate;
// they never overlap. All outputs are driven straight from registers.

module expr_result_unpacker #(
    parameter int BEAT_W = 10,
    parameter int OUT_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [BEAT_W-1:0] in_data,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [4:0]        out_idx,
    output logic [OUT_W-1:0]  out_data,
    output logic              out_signed,
    output logic              out_last,
    output logic              frame_err
);

    localparam int N_BEATS = 90 / BEAT_W;
    localparam int CNT_W   = (N_BEATS > 1) ? $clog2(N_BEATS) : 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(N_BEATS - 1);
    localparam logic [4:0]       LAST_IDX  = 5'd17;

    typedef enum logic [0:0] {
        ST_COLLECT = 1'b0,
        ST_EMIT    = 1'b1
    } state_t;

    // Extract field k from the packed vector and extend it to OUT_W bits.
    // The table lists each field's LSB position, width and signedness.
    function automatic logic [OUT_W-1:0] field_ext(input logic [89:0] vec,
                                                   input logic [4:0]  k);
        logic [6:0]       lsb;
        logic [2:0]       w;
        logic             sgn;
        logic [5:0]       raw;
        logic [OUT_W-1:0] ext;
        case (k)
            5'd0:    begin lsb = 7'd86; w = 3'd4; sgn = 1'b0; end
            5'd1:    begin lsb = 7'd81; w = 3'd5; sgn = 1'b0; end
            5'd2:    begin lsb = 7'd75; w = 3'd6; sgn = 1'b0; end
            5'd3:    begin lsb = 7'd71; w = 3'd4; sgn = 1'b1; end
            5'd4:    begin lsb = 7'd66; w = 3'd5; sgn = 1'b1; end
            5'd5:    begin lsb = 7'd60; w = 3'd6; sgn = 1'b1; end
            5'd6:    begin lsb = 7'd56; w = 3'd4; sgn = 1'b0; end
            5'd7:    begin lsb = 7'd51; w = 3'd5; sgn = 1'b0; end
            5'd8:    begin lsb = 7'd45; w = 3'd6; sgn = 1'b0; end
            5'd9:    begin lsb = 7'd41; w = 3'd4; sgn = 1'b1; end
            5'd10:   begin lsb = 7'd36; w = 3'd5; sgn = 1'b1; end
            5'd11:   begin lsb = 7'd30; w = 3'd6; sgn = 1'b1; end
            5'd12:   begin lsb = 7'd26; w = 3'd4; sgn = 1'b0; end
            5'd13:   begin lsb = 7'd21; w = 3'd5; sgn = 1'b0; end
            5'd14:   begin lsb = 7'd15; w = 3'd6; sgn = 1'b0; end
            5'd15:   begin lsb = 7'd11; w = 3'd4; sgn = 1'b1; end
            5'd16:   begin lsb = 7'd6;  w = 3'd5; sgn = 1'b1; end
            5'd17:   begin lsb = 7'd0;  w = 3'd6; sgn = 1'b1; end
            default: begin lsb = 7'd0;  w = 3'd4; sgn = 1'b0; end
        endcase
        raw = 6'(vec >> lsb);
        ext = (sgn && raw[w - 3'd1]) ? {OUT_W{1'b1}} : {OUT_W{1'b0}};
        for (int b = 0; b < 6; b++) begin
            ext[b] = (b < int'(w)) ? raw[b] : ext[b];
        end
        return ext;
    endfunction

    state_t           state_r, state_nxt;
    logic [89:0]      shift_r, shift_nxt, shifted_s;
    logic [CNT_W-1:0] cnt_r, cnt_nxt;
    logic [4:0]       idx_r, idx_nxt;
    logic             err_nxt;

    logic             in_ready_r, in_ready_nxt;
    logic             out_valid_r, out_valid_nxt;
    logic [4:0]       out_idx_r, out_idx_nxt;
    logic [OUT_W-1:0] out_data_r, out_data_nxt;
    logic             out_signed_r, out_signed_nxt;
    logic             out_last_r, out_last_nxt;
    logic             frame_err_r;

    // Next-state logic: beat collection with framing checks, then field stepping.
    always_comb begin
        state_nxt = state_r;
        shift_nxt = shift_r;
        cnt_nxt   = cnt_r;
        idx_nxt   = idx_r;
        err_nxt   = 1'b0;
        shifted_s = (shift_r << BEAT_W) | 90'(in_data);
        case (state_r)
            ST_COLLECT: begin
                if (in_valid && in_ready_r) begin
                    if (cnt_r == LAST_BEAT) begin
                        cnt_nxt = '0;
                        if (in_last) begin
                            shift_nxt = shifted_s;
                            idx_nxt   = 5'd0;
                            state_nxt = ST_EMIT;
                        end else begin
                            // Full-length frame without a terminator: discard.
                            err_nxt = 1'b1;
                        end
                    end else if (in_last) begin
                        // Terminator arrived early: discard the short frame.
                        cnt_nxt = '0;
                        err_nxt = 1'b1;
                    end else begin
                        shift_nxt = shifted_s;
                        cnt_nxt   = cnt_r + CNT_W'(1);
                    end
                end else begin
                    state_nxt = state_r;
                end
            end
            ST_EMIT: begin
                if (out_valid_r && out_ready) begin
                    if (idx_r == LAST_IDX) begin
                        idx_nxt   = 5'd0;
                        cnt_nxt   = '0;
                        state_nxt = ST_COLLECT;
                    end else begin
                        idx_nxt = idx_r + 5'd1;
                    end
                end else begin
                    state_nxt = state_r;
                end
            end
            default: begin
                state_nxt = ST_COLLECT;
                cnt_nxt   = '0;
                idx_nxt   = 5'd0;
            end
        endcase
    end

    // Output pre-computation from next-state values so every port is a flop.
    always_comb begin
        in_ready_nxt   = 1'b0;
        out_valid_nxt  = 1'b0;
        out_idx_nxt    = 5'd0;
        out_data_nxt   = '0;
        out_signed_nxt = 1'b0;
        out_last_nxt   = 1'b0;
        if (state_nxt == ST_EMIT) begin
            out_valid_nxt  = 1'b1;
            out_idx_nxt    = idx_nxt;
            out_data_nxt   = field_ext(shift_nxt, idx_nxt);
            out_signed_nxt = (idx_nxt % 5'd6) >= 5'd3;
            out_last_nxt   = (idx_nxt == LAST_IDX);
        end else begin
            in_ready_nxt = 1'b1;
        end
    end

    // State, datapath and registered outputs with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= ST_COLLECT;
            shift_r      <= '0;
            cnt_r        <= '0;
            idx_r        <= 5'd0;
            in_ready_r   <= 1'b0;
            out_valid_r  <= 1'b0;
            out_idx_r    <= 5'd0;
            out_data_r   <= '0;
            out_signed_r <= 1'b0;
            out_last_r   <= 1'b0;
            frame_err_r  <= 1'b0;
        end else begin
            state_r      <= state_nxt;
            shift_r      <= shift_nxt;
            cnt_r        <= cnt_nxt;
            idx_r        <= idx_nxt;
            in_ready_r   <= in_ready_nxt;
            out_valid_r  <= out_valid_nxt;
            out_idx_r    <= out_idx_nxt;
            out_data_r   <= out_data_nxt;
            out_signed_r <= out_signed_nxt;
            out_last_r   <= out_last_nxt;
            frame_err_r  <= err_nxt;
        end
    end

    assign in_ready   = in_ready_r;
    assign out_valid  = out_valid_r;
    assign out_idx    = out_idx_r;
    assign out_data   = out_data_r;
    assign out_signed = out_signed_r;
    assign out_last   = out_last_r;
    assign frame_err  = frame_err_r;

endmodule

// File: tb/tb_expr_result_unpacker.sv
// Directed self-checking bench for expr_result_unpacker at default parameters.

module tb_expr_result_unpacker;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [9:0] in_data;
    logic       in_last;
    logic       out_valid;
    logic       out_ready;
    logic [4:0] out_idx;
    logic [7:0] out_data;
    logic       out_signed;
    logic       out_last;
    logic       frame_err;

    int n_pass  = 0;
    int n_total = 0;
    logic [7:0] got [18];

    expr_result_unpacker #(.BEAT_W(10), .OUT_W(8)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready), .out_idx(out_idx),
        .out_data(out_data), .out_signed(out_signed), .out_last(out_last),
        .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    // Reference field extraction computed from the layout formula.
    function automatic logic [7:0] exp_field(input logic [89:0] vec, input int k);
        int g, j, w, off, msb;
        logic [7:0] mask, v;
        g = k / 6;
        j = k % 6;
        w = 4 + (j % 3);
        case (j)
            0: off = 0;
            1: off = 4;
            2: off = 9;
            3: off = 15;
            4: off = 19;
            default: off = 24;
        endcase
        msb  = 89 - 30 * g - off;
        mask = 8'((1 << w) - 1);
        v    = 8'(vec >> (msb - w + 1)) & mask;
        if (j >= 3 && v[w-1]) v = v | ~mask;
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_beat(input logic [9:0] d, input logic last);
        int n = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        while (in_ready !== 1'b1 && n < 50) begin
            tick();
            n++;
        end
        if (in_ready !== 1'b1) begin
            n_total++;
            $display("FAIL in_ready_timeout: got %b want 1", in_ready);
        end
        tick();
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_data  = 10'd0;
    endtask

    task automatic send_frame(input logic [89:0] vec);
        for (int b = 0; b < 9; b++) send_beat(vec[89 - 10*b -: 10], b == 8);
    endtask

    // Consume all 18 fields, checking every visible output each cycle.
    task automatic drain(input logic [89:0] vec, input logic bp);
        int k = 0;
        int cyc = 0;
        while (k < 18 && cyc < 200) begin
            out_ready = bp ? ((cyc % 4 == 0) || (cyc % 4 == 3)) : 1'b1;
            got[k] = out_data;
            n_total++; if (out_valid !== 1'b1) $display("FAIL drain_valid k=%0d: got %b want 1", k, out_valid); else n_pass++;
            n_total++; if (out_idx !== 5'(k)) $display("FAIL drain_idx: got %0d want %0d", out_idx, k); else n_pass++;
            n_total++; if (out_data !== exp_field(vec, k)) $display("FAIL drain_data k=%0d: got %h want %h", k, out_data, exp_field(vec, k)); else n_pass++;
            n_total++; if (out_signed !== ((k % 6) >= 3)) $display("FAIL drain_signed k=%0d: got %b", k, out_signed); else n_pass++;
            n_total++; if (out_last !== (k == 17)) $display("FAIL drain_last k=%0d: got %b", k, out_last); else n_pass++;
            n_total++; if (in_ready !== 1'b0) $display("FAIL drain_in_ready k=%0d: got %b want 0", k, in_ready); else n_pass++;
            tick();
            if (out_ready) k++;
            cyc++;
        end
        out_ready = 1'b1;
        n_total++; if (k != 18) $display("FAIL drain_timeout: got %0d fields want 18", k); else n_pass++;
        n_total++; if (out_valid !== 1'b0) $display("FAIL drain_done_valid: got %b want 0", out_valid); else n_pass++;
        n_total++; if (in_ready !== 1'b1) $display("FAIL drain_done_in_ready: got %b want 1", in_ready); else n_pass++;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; in_data = 10'd0; in_last = 1'b0; out_ready = 1'b1;
        repeat (2) tick();
        n_total++; if (out_valid !== 1'b0) $display("FAIL rst_out_valid: got %b want 0", out_valid); else n_pass++;
        n_total++; if (out_idx !== 5'd0) $display("FAIL rst_out_idx: got %0d want 0", out_idx); else n_pass++;
        n_total++; if (out_data !== 8'h00) $display("FAIL rst_out_data: got %h want 00", out_data); else n_pass++;
        n_total++; if (out_signed !== 1'b0) $display("FAIL rst_out_signed: got %b want 0", out_signed); else n_pass++;
        n_total++; if (out_last !== 1'b0) $display("FAIL rst_out_last: got %b want 0", out_last); else n_pass++;
        n_total++; if (frame_err !== 1'b0) $display("FAIL rst_frame_err: got %b want 0", frame_err); else n_pass++;
        n_total++; if (in_ready !== 1'b0) $display("FAIL rst_in_ready: got %b want 0", in_ready); else n_pass++;
        rst = 1'b0;
        tick();
        n_total++; if (in_ready !== 1'b1) $display("FAIL rst_release_in_ready: got %b want 1", in_ready); else n_pass++;
    endtask

    task automatic test_all_ones();
        logic [89:0] vec = {90{1'b1}};
        for (int b = 0; b < 8; b++) send_beat(10'h3FF, 1'b0);
        n_total++; if (out_valid !== 1'b0) $display("FAIL ones_early_valid: got %b want 0", out_valid); else n_pass++;
        send_beat(10'h3FF, 1'b1);
        n_total++; if (out_valid !== 1'b1) $display("FAIL ones_latency_valid: got %b want 1", out_valid); else n_pass++;
        n_total++; if (frame_err !== 1'b0) $display("FAIL ones_frame_err: got %b want 0", frame_err); else n_pass++;
        drain(vec, 1'b0);
        n_total++; if (got[0] !== 8'h0F) $display("FAIL ones_idx0: got %h want 0f", got[0]); else n_pass++;
        n_total++; if (got[1] !== 8'h1F) $display("FAIL ones_idx1: got %h want 1f", got[1]); else n_pass++;
        n_total++; if (got[2] !== 8'h3F) $display("FAIL ones_idx2: got %h want 3f", got[2]); else n_pass++;
        n_total++; if (got[4] !== 8'hFF) $display("FAIL ones_idx4: got %h want ff", got[4]); else n_pass++;
        n_total++; if (got[8] !== 8'h3F) $display("FAIL ones_idx8: got %h want 3f", got[8]); else n_pass++;
        n_total++; if (got[17] !== 8'hFF) $display("FAIL ones_idx17: got %h want ff", got[17]); else n_pass++;
    endtask

    task automatic test_sign();
        logic [89:0] vec = {10'h000, 10'h000, 10'h020, 60'd0};
        send_frame(vec);
        drain(vec, 1'b0);
        for (int k = 0; k < 18; k++) begin
            n_total++;
            if (k == 5) begin
                if (got[k] !== 8'hE0) $display("FAIL sign_idx5: got %h want e0", got[k]); else n_pass++;
            end else begin
                if (got[k] !== 8'h00) $display("FAIL sign_zero k=%0d: got %h want 00", k, got[k]); else n_pass++;
            end
        end
    endtask

    task automatic test_single_bits();
        logic [89:0] lsb_vec = 90'd1;
        logic [89:0] msb_vec = {10'h200, 80'd0};
        send_frame(lsb_vec);
        drain(lsb_vec, 1'b0);
        n_total++; if (got[17] !== 8'h01) $display("FAIL lsb_idx17: got %h want 01", got[17]); else n_pass++;
        send_frame(msb_vec);
        drain(msb_vec, 1'b0);
        n_total++; if (got[0] !== 8'h08) $display("FAIL msb_idx0: got %h want 08", got[0]); else n_pass++;
    endtask

    task automatic test_frame_err();
        logic [89:0] vec = 90'h2_A5C3_0F1E_9B7D_4826_F1C0;
        for (int b = 0; b < 3; b++) send_beat(10'h155, 1'b0);
        send_beat(10'h155, 1'b1);
        n_total++; if (frame_err !== 1'b1) $display("FAIL early_err_pulse: got %b want 1", frame_err); else n_pass++;
        tick();
        n_total++; if (frame_err !== 1'b0) $display("FAIL early_err_single: got %b want 0", frame_err); else n_pass++;
        repeat (3) tick();
        n_total++; if (out_valid !== 1'b0) $display("FAIL early_no_output: got %b want 0", out_valid); else n_pass++;
        send_frame(vec);
        n_total++; if (frame_err !== 1'b0) $display("FAIL recover_err: got %b want 0", frame_err); else n_pass++;
        drain(vec, 1'b0);
        for (int b = 0; b < 9; b++) send_beat(10'h3FF, 1'b0);
        n_total++; if (frame_err !== 1'b1) $display("FAIL nolast_err_pulse: got %b want 1", frame_err); else n_pass++;
        n_total++; if (out_valid !== 1'b0) $display("FAIL nolast_no_output: got %b want 0", out_valid); else n_pass++;
        tick();
        n_total++; if (frame_err !== 1'b0) $display("FAIL nolast_err_single: got %b want 0", frame_err); else n_pass++;
        repeat (3) tick();
        n_total++; if (out_valid !== 1'b0) $display("FAIL nolast_still_idle: got %b want 0", out_valid); else n_pass++;
        n_total++; if (in_ready !== 1'b1) $display("FAIL nolast_in_ready: got %b want 1", in_ready); else n_pass++;
    endtask

    task automatic test_backpressure();
        logic [89:0] vec = 90'h1_3579_BDF0_2468_ACE1_5A3C;
        send_frame(vec);
        drain(vec, 1'b1);
    endtask

    task automatic test_reset_mid_emit();
        logic [89:0] vec  = {90{1'b1}};
        logic [89:0] vec2 = 90'h3_0C30_C30C_30C3_0C30_C30C;
        send_frame(vec);
        out_ready = 1'b1;
        repeat (7) tick();
        n_total++; if (out_idx !== 5'd7) $display("FAIL mid_idx7: got %0d want 7", out_idx); else n_pass++;
        out_ready = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_total++; if (out_valid !== 1'b0) $display("FAIL mid_rst_valid: got %b want 0", out_valid); else n_pass++;
        n_total++; if (frame_err !== 1'b0) $display("FAIL mid_rst_err: got %b want 0", frame_err); else n_pass++;
        tick();
        send_frame(vec2);
        n_total++; if (frame_err !== 1'b0) $display("FAIL mid_next_err: got %b want 0", frame_err); else n_pass++;
        drain(vec2, 1'b0);
    endtask

    initial begin
        test_reset();
        test_all_ones();
        test_sign();
        test_single_bits();
        test_frame_err();
        test_backpressure();
        test_reset_mid_emit();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
